// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response bundle between the EX-stage issue
// logic (master) and the iterative multiply/divide unit (slave).
interface multicycle_alu_if #(
   parameter int DATA_W = 16,
   parameter int RD_W   = 4
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [RD_W-1:0]   rd_in;
   logic              flush;
   logic [DATA_W-1:0] result;
   logic [RD_W-1:0]   result_rd;
   logic [RD_W-1:0]   busy_rd;
   logic [1:0]        alu_status;

   modport master (
      output start, op, operand_a, operand_b, rd_in, flush,
      input  result, result_rd, busy_rd, alu_status
   );

   modport slave (
      input  start, op, operand_a, operand_b, rd_in, flush,
      output result, result_rd, busy_rd, alu_status
   );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: iterative unsigned MUL / MULH / DIV / REM beside the
// single-cycle ALU. alu_status is the FSM state itself (00 IDLE, 01 DONE,
// 10 BUSY_MUL, 11 BUSY_DIV); anything above 01 stalls the front end.
// Optional build macro MALU_RADIX4_EN: retire two bits per busy cycle
// (DATA_W/2 busy cycles, DATA_W must be even). Default build is radix-2.
module multicycle_alu #(
   parameter int DATA_W = 16,
   parameter int RD_W   = 4
) (
   input  logic            clk,
   input  logic            rst,
   multicycle_alu_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_DONE = 2'b01;
   localparam logic [1:0] ST_MUL  = 2'b10;
   localparam logic [1:0] ST_DIV  = 2'b11;

   // one extra counter bit so the terminal compare never sees a wrapped value
   localparam int CNT_W = $clog2(DATA_W) + 1;
`ifdef MALU_RADIX4_EN
   localparam int STEPS = DATA_W / 2;
`else
   localparam int STEPS = DATA_W;
`endif
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEPS - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] ONES_W   = {DATA_W{1'b1}};
   localparam logic [RD_W-1:0]   ZERO_RD  = {RD_W{1'b0}};

   // one restoring-division step: shift in the next dividend bit, subtract
   // the divisor when it fits; returns {remainder, quotient/dividend}
   function automatic logic [2*DATA_W-1:0] div_bit(
      input logic [DATA_W-1:0] r,
      input logic [DATA_W-1:0] q,
      input logic [DATA_W-1:0] d
   );
      logic [DATA_W:0] shifted;
      logic [DATA_W:0] diff;
      shifted = {r, q[DATA_W-1]};
      diff    = shifted - {1'b0, d};
      if (diff[DATA_W]) begin
         return {shifted[DATA_W-1:0], q[DATA_W-2:0], 1'b0};
      end else begin
         return {diff[DATA_W-1:0], q[DATA_W-2:0], 1'b1};
      end
   endfunction

`ifdef MALU_RADIX4_EN
   // two multiplier bits per step: add 0, A, 2A or 3A then shift by two
   function automatic logic [2*DATA_W-1:0] mul_iter(
      input logic [2*DATA_W-1:0] p,
      input logic [DATA_W-1:0]   a,
      input logic [DATA_W+1:0]   a3
   );
      logic [DATA_W+1:0] addend;
      logic [DATA_W+1:0] sum;
      case (p[1:0])
         2'b00:   addend = {(DATA_W+2){1'b0}};
         2'b01:   addend = {2'b00, a};
         2'b10:   addend = {1'b0, a, 1'b0};
         2'b11:   addend = a3;
         default: addend = {(DATA_W+2){1'b0}};
      endcase
      sum = {2'b00, p[2*DATA_W-1:DATA_W]} + addend;
      return {sum, p[DATA_W-1:2]};
   endfunction

   // two chained restoring steps
   function automatic logic [2*DATA_W-1:0] div_iter(
      input logic [DATA_W-1:0] r,
      input logic [DATA_W-1:0] q,
      input logic [DATA_W-1:0] d
   );
      logic [2*DATA_W-1:0] first;
      first = div_bit(r, q, d);
      return div_bit(first[2*DATA_W-1:DATA_W], first[DATA_W-1:0], d);
   endfunction
`else
   // one multiplier bit per step: conditionally add A then shift by one
   function automatic logic [2*DATA_W-1:0] mul_iter(
      input logic [2*DATA_W-1:0] p,
      input logic [DATA_W-1:0]   a
   );
      logic [DATA_W:0] sum;
      sum = {1'b0, p[2*DATA_W-1:DATA_W]} + (p[0] ? {1'b0, a} : {(DATA_W+1){1'b0}});
      return {sum, p[DATA_W-1:1]};
   endfunction

   function automatic logic [2*DATA_W-1:0] div_iter(
      input logic [DATA_W-1:0] r,
      input logic [DATA_W-1:0] q,
      input logic [DATA_W-1:0] d
   );
      return div_bit(r, q, d);
   endfunction
`endif

   logic [1:0]          state,     state_n;
   logic [CNT_W-1:0]    cnt,       cnt_n;
   logic [2*DATA_W-1:0] prod,      prod_n;
   logic [DATA_W-1:0]   rem,       rem_n;
   logic [DATA_W-1:0]   quo,       quo_n;
   logic [DATA_W-1:0]   mcand,     mcand_n;
   logic [DATA_W-1:0]   divisor,   divisor_n;
   logic                hi_sel,    hi_sel_n;
   logic [RD_W-1:0]     rd_q,      rd_n;
   logic [DATA_W-1:0]   result_q,  result_n;
   logic [RD_W-1:0]     result_rd_q, result_rd_n;
   logic [RD_W-1:0]     busy_rd_q,   busy_rd_n;
   logic [2*DATA_W-1:0] mul_next;
   logic [2*DATA_W-1:0] div_next;
`ifdef MALU_RADIX4_EN
   logic [DATA_W+1:0]   mcand3,    mcand3_n;

   assign mul_next = mul_iter(prod, mcand, mcand3);
`else
   assign mul_next = mul_iter(prod, mcand);
`endif
   assign div_next = div_iter(rem, quo, divisor);

   // Next-state, datapath and output-register decode; flush overrides all
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      prod_n    = prod;
      rem_n     = rem;
      quo_n     = quo;
      mcand_n   = mcand;
      divisor_n = divisor;
      hi_sel_n  = hi_sel;
      rd_n      = rd_q;
      result_n  = result_q;
`ifdef MALU_RADIX4_EN
      mcand3_n  = mcand3;
`endif
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               hi_sel_n = bus.op[0];
               rd_n     = bus.rd_in;
               cnt_n    = CNT_ZERO;
               if (!bus.op[1]) begin
                  state_n = ST_MUL;
                  mcand_n = bus.operand_a;
                  prod_n  = {ZERO_W, bus.operand_b};
`ifdef MALU_RADIX4_EN
                  mcand3_n = {2'b00, bus.operand_a} + {1'b0, bus.operand_a, 1'b0};
`endif
               end else if (bus.operand_b != ZERO_W) begin
                  state_n   = ST_DIV;
                  divisor_n = bus.operand_b;
                  rem_n     = ZERO_W;
                  quo_n     = bus.operand_a;
               end else begin
                  // divide by zero: answer immediately, no busy period
                  state_n  = ST_DONE;
                  result_n = bus.op[0] ? bus.operand_a : ONES_W;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_MUL: begin
            prod_n = mul_next;
            if (cnt == CNT_LAST) begin
               state_n  = ST_DONE;
               cnt_n    = CNT_ZERO;
               result_n = hi_sel ? mul_next[2*DATA_W-1:DATA_W] : mul_next[DATA_W-1:0];
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         ST_DIV: begin
            rem_n = div_next[2*DATA_W-1:DATA_W];
            quo_n = div_next[DATA_W-1:0];
            if (cnt == CNT_LAST) begin
               state_n  = ST_DONE;
               cnt_n    = CNT_ZERO;
               result_n = hi_sel ? div_next[2*DATA_W-1:DATA_W] : div_next[DATA_W-1:0];
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      if (bus.flush) begin
         state_n  = ST_IDLE;
         result_n = result_q;
      end else begin
         state_n = state_n;
      end

      busy_rd_n   = state_n[1] ? rd_n : ZERO_RD;
      result_rd_n = (state_n == ST_DONE) ? rd_n : ZERO_RD;
   end

   // State, datapath and registered outputs; rst clears everything at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= CNT_ZERO;
         prod        <= {2{ZERO_W}};
         rem         <= ZERO_W;
         quo         <= ZERO_W;
         mcand       <= ZERO_W;
         divisor     <= ZERO_W;
         hi_sel      <= 1'b0;
         rd_q        <= ZERO_RD;
         result_q    <= ZERO_W;
         result_rd_q <= ZERO_RD;
         busy_rd_q   <= ZERO_RD;
`ifdef MALU_RADIX4_EN
         mcand3      <= {(DATA_W+2){1'b0}};
`endif
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         prod        <= prod_n;
         rem         <= rem_n;
         quo         <= quo_n;
         mcand       <= mcand_n;
         divisor     <= divisor_n;
         hi_sel      <= hi_sel_n;
         rd_q        <= rd_n;
         result_q    <= result_n;
         result_rd_q <= result_rd_n;
         busy_rd_q   <= busy_rd_n;
`ifdef MALU_RADIX4_EN
         mcand3      <= mcand3_n;
`endif
      end
   end

   assign bus.alu_status = state;
   assign bus.result     = result_q;
   assign bus.result_rd  = result_rd_q;
   assign bus.busy_rd    = busy_rd_q;
endmodule
